// File: rtl/div_sequencer.sv
`timescale 1ns/1ps
// div_sequencer: multi-cycle signed 32-bit divider controller.
//
// Runs a non-restoring divide step for 32 iterations on magnitudes, then
// applies the remainder correction and sign fix-up. The result is presented
// with a one-cycle ready pulse.
//
// Optional feature macro: DIV_REMAINDER_EN (adds data_remainder output).
//
// Ports:
//   clock           system clock, rising edge active
//   reset_n         asynchronous active-low reset
//   ctrl_DIV        start pulse, accepted only while idle
//   data_operandA   signed dividend, sampled on the start edge
//   data_operandB   signed divisor, sampled on the start edge
//   data_result     signed quotient, held until the next accepted start
//   data_exception  divide-by-zero flag, valid with data_result
//   data_resultRDY  one-cycle pulse marking the outputs valid
//   busy            high from the cycle after a start until ready drops
//   data_remainder  signed remainder (only with DIV_REMAINDER_EN)
module div_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
`ifdef DIV_REMAINDER_EN
    output logic [WIDTH-1:0] data_remainder,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // Partial remainder carries one extra sign bit so divisor magnitudes up
    // to 2^31 cannot overflow the shifted value.
    logic [WIDTH:0]     a_q, a_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic               sign_quo_q, sign_quo_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               exc_q, exc_d;
`ifdef DIV_REMAINDER_EN
    logic               sign_rem_q, sign_rem_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   rem_fix;
`endif

    logic [WIDTH:0]     a_shift;
    logic [WIDTH:0]     a_new;
    logic [WIDTH-1:0]   q_new;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;

    // Single non-restoring step: shift {A,Q} left, add or subtract M by the
    // sign of the previous partial remainder, quotient bit is the new sign inverted.
    always_comb begin
        a_shift = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
        a_new   = a_q[WIDTH] ? (a_shift + {1'b0, m_q}) : (a_shift - {1'b0, m_q});
        q_new   = {q_q[WIDTH-2:0], ~a_new[WIDTH]};
    end

    // Two's complement wrap: |INT_MIN| stays 0x80000000, read as unsigned 2^31.
    assign abs_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign abs_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

`ifdef DIV_REMAINDER_EN
    // Corrected remainder lies in [0, M), so the low WIDTH bits are exact.
    assign rem_fix = a_q[WIDTH] ? (a_q[WIDTH-1:0] + m_q) : a_q[WIDTH-1:0];
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        q_d        = q_q;
        m_d        = m_q;
        sign_quo_d = sign_quo_q;
        result_d   = result_q;
        exc_d      = exc_q;
`ifdef DIV_REMAINDER_EN
        sign_rem_d = sign_rem_q;
        rem_d      = rem_q;
`endif
        case (state_q)
            StIdle: begin
                if (ctrl_DIV) begin
                    sign_quo_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                    a_d        = '0;
                    q_d        = abs_a;
                    m_d        = abs_b;
                    cnt_d      = '0;
`ifdef DIV_REMAINDER_EN
                    sign_rem_d = data_operandA[WIDTH-1];
`endif
                    if (data_operandB == '0) begin
                        state_d  = StDone;
                        result_d = '0;
                        exc_d    = 1'b1;
`ifdef DIV_REMAINDER_EN
                        rem_d    = data_operandA;
`endif
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                a_d   = a_new;
                q_d   = q_new;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                result_d = sign_quo_q ? -q_q : q_q;
                exc_d    = 1'b0;
`ifdef DIV_REMAINDER_EN
                rem_d    = sign_rem_q ? -rem_fix : rem_fix;
`endif
                state_d  = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            a_q        <= '0;
            q_q        <= '0;
            m_q        <= '0;
            sign_quo_q <= 1'b0;
            result_q   <= '0;
            exc_q      <= 1'b0;
`ifdef DIV_REMAINDER_EN
            sign_rem_q <= 1'b0;
            rem_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            q_q        <= q_d;
            m_q        <= m_d;
            sign_quo_q <= sign_quo_d;
            result_q   <= result_d;
            exc_q      <= exc_d;
`ifdef DIV_REMAINDER_EN
            sign_rem_q <= sign_rem_d;
            rem_q      <= rem_d;
`endif
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == StDone);
    assign busy           = (state_q != StIdle);
`ifdef DIV_REMAINDER_EN
    assign data_remainder = rem_q;
`endif

endmodule

// File: tb/tb_div_sequencer.sv
`timescale 1ns/1ps
// Self-checking bench for div_sequencer: directed and random divides checked
// against plain signed arithmetic, plus latency, busy, ignore and reset cases.
module tb_div_sequencer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;
`ifdef DIV_REMAINDER_EN
    logic [31:0] data_remainder;
`endif

    int n_vec = 0;
    int n_err = 0;

    div_sequencer #(
        .WIDTH(32),
        .CNT_W(6)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
`ifdef DIV_REMAINDER_EN
        .data_remainder (data_remainder),
`endif
        .busy           (busy)
    );

    always #5 clock = ~clock;

    // Reference: truncating signed division in 64-bit arithmetic, wrapped to 32 bits.
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic exc);
        longint la;
        longint lb;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        if (b == 32'd0) begin
            q   = 32'd0;
            r   = a;
            exc = 1'b1;
        end else begin
            q   = 32'(la / lb);
            r   = 32'(la % lb);
            exc = 1'b0;
        end
    endtask

    // pulse_at >= 0: extra ctrl_DIV (9/3) on that busy cycle; -2: pulse during DONE.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           input int pulse_at, input string name);
        logic [31:0] eq;
        logic [31:0] er;
        logic        ex;
        int          cyc;
        int          exp_lat;
        model(a, b, eq, er, ex);
        exp_lat = (b == 32'd0) ? 0 : 33;
        @(negedge clock);
        ctrl_DIV = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        cyc = 0;
        while (!data_resultRDY && cyc < 60) begin
            n_vec++;
            if (busy !== 1'b1) begin
                n_err++;
                $display("FAIL %s busy cyc %0d: got %b want 1", name, cyc, busy);
            end
            if (cyc == pulse_at) begin
                ctrl_DIV = 1'b1;
                data_operandA = 32'd9;
                data_operandB = 32'd3;
            end else begin
                ctrl_DIV = 1'b0;
            end
            @(negedge clock);
            cyc++;
        end
        ctrl_DIV = 1'b0;
        n_vec++;
        if (cyc !== exp_lat) begin
            n_err++;
            $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_lat);
        end
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s busy at ready: got %b want 1", name, busy);
        end
        n_vec++;
        if (data_result !== eq) begin
            n_err++;
            $display("FAIL %s result: got %h want %h", name, data_result, eq);
        end
        n_vec++;
        if (data_exception !== ex) begin
            n_err++;
            $display("FAIL %s exception: got %b want %b", name, data_exception, ex);
        end
`ifdef DIV_REMAINDER_EN
        n_vec++;
        if (data_remainder !== er) begin
            n_err++;
            $display("FAIL %s remainder: got %h want %h", name, data_remainder, er);
        end
`endif
        if (pulse_at == -2) begin
            ctrl_DIV = 1'b1;
            data_operandA = 32'd9;
            data_operandB = 32'd3;
        end
        @(negedge clock);
        ctrl_DIV = 1'b0;
        n_vec++;
        if (data_resultRDY !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s after ready: got rdy=%b busy=%b want 0 0",
                     name, data_resultRDY, busy);
        end
        n_vec++;
        if (data_result !== eq) begin
            n_err++;
            $display("FAIL %s held result: got %h want %h", name, data_result, eq);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        n_vec++;
        if (data_result !== 32'd0 || data_exception !== 1'b0 ||
            data_resultRDY !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got res=%h exc=%b rdy=%b busy=%b want 0 0 0 0",
                     data_result, data_exception, data_resultRDY, busy);
        end
        reset_n = 1'b1;
        @(negedge clock);
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_reset busy: got %b want 0", busy);
        end
    endtask

    task automatic test_directed();
        run_div(32'd100, 32'd7, -1, "100/7");
        run_div(32'hFFFF_FF9C, 32'd7, -1, "-100/7");
        run_div(32'd100, 32'hFFFF_FFF9, -1, "100/-7");
        run_div(32'd7, 32'd0, -1, "7/0");
        run_div(32'h8000_0000, 32'hFFFF_FFFF, -1, "min/-1");
        run_div(32'h8000_0000, 32'd1, -1, "min/1");
        run_div(32'h7FFF_FFFF, 32'h8000_0000, -1, "max/min");
        run_div(32'h8000_0000, 32'h8000_0000, -1, "min/min");
    endtask

    task automatic test_ignore_start();
        run_div(32'd100, 32'd7, 10, "ignore_busy");
        run_div(32'd9, 32'd3, -1, "9/3");
        run_div(32'd100, 32'd7, -2, "ignore_done");
        run_div(32'd7, 32'd0, -2, "ignore_done_dz");
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        ctrl_DIV = 1'b1;
        data_operandA = 32'd100;
        data_operandB = 32'd7;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        repeat (20) @(negedge clock);
        reset_n = 1'b0;
        #1;
        n_vec++;
        if (data_result !== 32'd0 || data_exception !== 1'b0 ||
            data_resultRDY !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset outputs: got res=%h exc=%b rdy=%b busy=%b want 0 0 0 0",
                     data_result, data_exception, data_resultRDY, busy);
        end
`ifdef DIV_REMAINDER_EN
        n_vec++;
        if (data_remainder !== 32'd0) begin
            n_err++;
            $display("FAIL mid_reset remainder: got %h want 0", data_remainder);
        end
`endif
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            n_vec++;
            if (data_resultRDY !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL mid_reset no_ready cyc %0d: got rdy=%b busy=%b want 0 0",
                         i, data_resultRDY, busy);
            end
        end
        run_div(32'd50, 32'd5, -1, "50/5");
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: a = 32'h8000_0000;
                3: b = 32'($urandom_range(1, 20));
                4: b = 32'h8000_0000;
                default: ;
            endcase
            run_div(a, b, -1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Multi-cycle signed 32-bit divider controller built around the existing single-step non-restoring divide stage.
- Feeds the stage its A, Q and M registers and consumes Anew and Qnew for 32 iterations.
- Applies final remainder correction and sign fix-up, then presents the result with a one-cycle ready pulse.
- Sits in the CPU execute path beside the multiplier and is driven by ctrl_DIV.

Parameters:
WIDTH, 32, operand/result width; only 32 is supported because the step stage is fixed at 32 bits.
CNT_W, 6, iteration counter width; must hold the values 0..WIDTH.

Ports:
clock  input  1  system clock; all state changes on the rising edge.
reset_n  input  1  asynchronous, active-low reset.
ctrl_DIV  input  1  start pulse; sampled on a rising edge while idle.
data_operandA  input  32  signed dividend; sampled on the start edge.
data_operandB  input  32  signed divisor; sampled on the start edge.
data_result  output  32  signed quotient; held until the next accepted start.
data_exception  output  1  divide-by-zero flag; valid with data_result.
data_resultRDY  output  1  one-cycle pulse marking data_result and data_exception valid.
busy  output  1  high from the cycle after an accepted start until data_resultRDY drops.

Behaviour:
- Reset:
  - Clock and reset are as decided: one clock; reset is asynchronous and active-low.
  - reset_n low forces state IDLE, counter 0, and all internal registers to 0.
  - data_result=0, data_exception=0, data_resultRDY=0, busy=0.
  - Reset mid-operation abandons the divide; no ready pulse is produced.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - ctrl_DIV=1 at an edge latches sign_q = A[31]^B[31] and sign_r = A[31].
  - Also latches A_reg=0, Q_reg=|operandA|, M_reg=|operandB|, counter=0.
  - If operandB==0, go to DONE with data_result=0 and data_exception=1.
  - Otherwise go to RUN with data_exception=0.
- RUN:
  - Each edge loads A_reg<=Anew and Q_reg<=Qnew from the step stage, and counter+1.
  - The step stage adds M when A_reg[31]=1, otherwise subtracts M.
  - On the edge that completes step 32 (counter==31), go to FIX.
- FIX, one edge:
  - If A_reg[31]=1, remainder = A_reg+M_reg; else remainder = A_reg.
  - data_result <= sign_q ? -Q_reg : Q_reg.
  - Then go to DONE.
- DONE:
  - data_resultRDY=1 for exactly this one cycle, then go to IDLE on the next edge.
- Latency:
  - Normal divide: ready in the cycle after the 34th edge counted from the start edge (start edge = edge 0; edge 33 enters DONE).
  - Divide-by-zero: ready in the cycle after the start edge.
- Abs/negate use 32-bit two's complement wrap.
  - |0x80000000| = 0x80000000, treated as unsigned 2^31 magnitude.
  - INT_MIN / -1 therefore gives data_result = 0x80000000 with exception=0.
- ctrl_DIV while busy or in DONE is ignored; operands are not re-sampled. A new start is accepted only in IDLE.
- Operand changes after the start edge have no effect.
- Outputs change only in FIX or on the IDLE->DONE divide-by-zero path.

Optional Feature:
- Macro: DIV_REMAINDER_EN.
- Defined:
  - Adds output data_remainder, 32 bits.
  - Loaded in FIX with sign_r ? -remainder : remainder, and on divide-by-zero with operandA.
  - Reset value 0; held until the next accepted start.
- Undefined:
  - Port absent.
  - Correction adder and remainder register omitted.
  - Quotient timing unchanged.

Test Plan:
- A=100, B=7, one-cycle start -> data_result=14, exception=0, ready pulse exactly 1 cycle at the specified latency, busy high throughout; with DIV_REMAINDER_EN, remainder=2.
- A=-100 (0xFFFFFF9C), B=7 -> result=0xFFFFFFF2 (-14); remainder=0xFFFFFFFE (-2). A=100, B=-7 -> result=-14, remainder=2.
- A=7, B=0 -> ready in the cycle after the start edge, result=0, exception=1; with the feature, remainder=7.
- A=0x80000000, B=0xFFFFFFFF -> result=0x80000000, exception=0. A=0x80000000, B=1 -> result=0x80000000.
- Start 100/7, pulse ctrl_DIV with 9/3 at step 10 -> ignored, result=14. Then 9/3 from IDLE -> result=3.
- Start 100/7, drop reset_n at step 20 -> all outputs 0 immediately with no ready pulse. After release, 50/5 -> result=10.
